// File: rtl/spike_dec_pkg.sv
// Shared types and default sizing for the spike-rate decoder.
package spike_dec_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   localparam int DEF_WINDOW_LOG2 = 8;
   localparam int DEF_COUNT_W     = 8;

endpackage

// File: rtl/spike_sat_counter.sv
// Saturating up-counter with synchronous clear; sum_o already includes this cycle's increment.
module spike_sat_counter
   import spike_dec_pkg::*;
#(
   parameter int W = DEF_COUNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] sum_o
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      if (cnt_q == CNT_MAX) begin
         sum_o = CNT_MAX;
      end else begin
         sum_o = cnt_q + W'(inc_i);
      end
      cnt_d = clr_i ? '0 : sum_o;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per 2**WINDOW_LOG2-cycle window and offers each count through a valid/ready handshake.
// Define SPIKE_RATE_DECODER_FIRST_SPIKE_EN to also report the first-spike latency of each window.
module spike_rate_decoder
   import spike_dec_pkg::*;
#(
   parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
   parameter int COUNT_W     = DEF_COUNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   spike_in,
   output logic [COUNT_W-1:0]     rate_out,
   output logic                   rate_valid,
   input  logic                   rate_ready,
   output logic                   overrun
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
   ,
   output logic [WINDOW_LOG2-1:0] first_lat,
   output logic                   first_seen
`endif
);

   localparam logic [WINDOW_LOG2-1:0] WIN_MAX = '1;

   state_e                 state_q, state_d;
   logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
   logic [COUNT_W-1:0]     rate_q, rate_d;
   logic                   valid_q, valid_d;
   logic                   ovr_q, ovr_d;
   logic                   active;
   logic                   win_end;
   logic [COUNT_W-1:0]     spike_sum;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: each always_comb assigns defaults first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ena)  state_d = COUNT;
         COUNT:   if (!ena) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A COUNT cycle with ena low is the abort edge, not a window sample.
   always_comb begin
      active  = (state_q == COUNT) && ena;
      win_end = active && (wcnt_q == WIN_MAX);
   end

   assign wcnt_d = active ? wcnt_q + 1'b1 : '0;

   spike_sat_counter #(
      .W (COUNT_W)
   ) u_spike_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (!active || win_end),
      .inc_i (active && spike_in),
      .sum_o (spike_sum)
   );

   always_comb begin
      rate_d  = rate_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (win_end) begin
         rate_d  = spike_sum;
         valid_d = 1'b1;
         if (valid_q && !rate_ready) ovr_d = 1'b1;
      end else if (valid_q && rate_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q  <= '0;
         rate_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         wcnt_q  <= wcnt_d;
         rate_q  <= rate_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rate_out   = rate_q;
   assign rate_valid = valid_q;
   assign overrun    = ovr_q;

`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
   logic                   run_seen_q, run_seen_d;
   logic [WINDOW_LOG2-1:0] run_lat_q, run_lat_d;
   logic                   fs_seen_q, fs_seen_d;
   logic [WINDOW_LOG2-1:0] fs_lat_q, fs_lat_d;
   logic                   win_seen;
   logic [WINDOW_LOG2-1:0] win_lat;

   // The window-end sample may itself be the first spike, so fold it in before loading.
   always_comb begin
      win_seen   = run_seen_q || (active && spike_in);
      win_lat    = run_seen_q ? run_lat_q : (spike_in ? wcnt_q : '0);
      run_seen_d = run_seen_q;
      run_lat_d  = run_lat_q;
      fs_seen_d  = fs_seen_q;
      fs_lat_d   = fs_lat_q;
      if (!active || win_end) begin
         run_seen_d = 1'b0;
         run_lat_d  = '0;
      end else if (spike_in && !run_seen_q) begin
         run_seen_d = 1'b1;
         run_lat_d  = wcnt_q;
      end
      if (win_end) begin
         fs_seen_d = win_seen;
         fs_lat_d  = win_lat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_seen_q <= 1'b0;
         run_lat_q  <= '0;
         fs_seen_q  <= 1'b0;
         fs_lat_q   <= '0;
      end else begin
         run_seen_q <= run_seen_d;
         run_lat_q  <= run_lat_d;
         fs_seen_q  <= fs_seen_d;
         fs_lat_q   <= fs_lat_d;
      end
   end

   assign first_seen = fs_seen_q;
   assign first_lat  = fs_lat_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with 16-cycle windows; a second COUNT_W=3 instance checks saturation.
module tb_spike_rate_decoder;

   localparam int WL = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic          spike_in;
   logic          rate_ready;
   logic [CW-1:0] rate_out;
   logic          rate_valid;
   logic          overrun;
   logic [2:0]    sat_out;
   logic          sat_valid;
   logic          sat_ovr;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
   logic [WL-1:0] first_lat;
   logic          first_seen;
   logic [WL-1:0] sat_first_lat;
   logic          sat_first_seen;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   spike_rate_decoder #(.WINDOW_LOG2(WL), .COUNT_W(CW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .spike_in   (spike_in),
      .rate_out   (rate_out),
      .rate_valid (rate_valid),
      .rate_ready (rate_ready),
      .overrun    (overrun)
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
      ,
      .first_lat  (first_lat),
      .first_seen (first_seen)
`endif
   );

   spike_rate_decoder #(.WINDOW_LOG2(WL), .COUNT_W(3)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .spike_in   (1'b1),
      .rate_out   (sat_out),
      .rate_valid (sat_valid),
      .rate_ready (1'b1),
      .overrun    (sat_ovr)
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
      ,
      .first_lat  (sat_first_lat),
      .first_seen (sat_first_seen)
`endif
   );

   typedef struct {
      logic [15:0] mask;
      int          exp_rate;
      int          exp_lat;
      int          exp_seen;
   } win_vec_t;

   win_vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full window starting at wcnt=0; bit i of each mask applies to window cycle i.
   task automatic run_window(input logic [15:0] mask, input logic [15:0] rdy,
                             input bit check_clear, input int hold);
      for (int i = 0; i < 16; i++) begin
         spike_in   = mask[i];
         rate_ready = rdy[i];
         tick();
         if (check_clear && i == 0) check("valid_one_cycle", int'(rate_valid), 0);
         if (hold >= 0 && i < 15) begin
            check("hold_rate_out", int'(rate_out), hold);
            check("hold_rate_valid", int'(rate_valid), 1);
         end
      end
      spike_in = 1'b0;
   endtask

   task automatic check_first(input string name, input int lat, input int seen);
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
      check({name, "_first_lat"}, int'(first_lat), lat);
      check({name, "_first_seen"}, int'(first_seen), seen);
`else
      if (lat < 0 || seen < 0) $display("%s: negative first-spike expectation", name);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{16'h8928,  5,  3, 1};
      vecs[1] = '{16'h0000,  0,  0, 0};
      vecs[2] = '{16'hFFFF, 16,  0, 1};
      vecs[3] = '{16'h8000,  1, 15, 1};
      vecs[4] = '{16'h0001,  1,  0, 1};
      vecs[5] = '{16'h0006,  2,  1, 1};

      rst = 1'b1; ena = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_rate_out", int'(rate_out), 0);
      check("reset_rate_valid", int'(rate_valid), 0);
      check("reset_overrun", int'(overrun), 0);
      check_first("reset", 0, 0);

      // IDLE->COUNT edge; the spike here must be ignored.
      ena = 1'b1; spike_in = 1'b1;
      tick();
      check("idle_no_result", int'(rate_valid), 0);

      foreach (vecs[k]) begin
         run_window(vecs[k].mask, 16'hFFFF, k > 0, -1);
         check($sformatf("win%0d_rate_out", k), int'(rate_out), vecs[k].exp_rate);
         check($sformatf("win%0d_rate_valid", k), int'(rate_valid), 1);
         check($sformatf("win%0d_overrun", k), int'(overrun), 0);
         check($sformatf("win%0d_sat_out", k), int'(sat_out), 7);
         check($sformatf("win%0d_sat_valid", k), int'(sat_valid), 1);
         check_first($sformatf("win%0d", k), vecs[k].exp_lat, vecs[k].exp_seen);
      end

      // Window end coincides with the handshake of a pending 4.
      run_window(16'h000F, 16'h0001, 1, -1);
      check("pend4_rate_out", int'(rate_out), 4);
      check("pend4_rate_valid", int'(rate_valid), 1);
      run_window(16'h0070, 16'h8000, 0, 4);
      check("hs_end_rate_out", int'(rate_out), 3);
      check("hs_end_rate_valid", int'(rate_valid), 1);
      check("hs_end_overrun", int'(overrun), 0);

      // Drop ena at wcnt=9 after 6 spikes; the partial window must vanish.
      rate_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         spike_in = (i < 6);
         tick();
      end
      check("partial_consumed", int'(rate_valid), 0);
      ena = 1'b0; spike_in = 1'b1;
      tick();
      check("abort_no_result", int'(rate_valid), 0);
      for (int i = 0; i < 3; i++) tick();
      check("idle_ignores_spikes", int'(rate_valid), 0);
      ena = 1'b1;
      tick();
      run_window(16'h0410, 16'hFFFF, 0, -1);
      check("fresh_rate_out", int'(rate_out), 2);
      check("fresh_rate_valid", int'(rate_valid), 1);
      check_first("fresh", 4, 1);

      // Two window ends without consumption: 3 overwritten by 9.
      run_window(16'h0007, 16'h0001, 1, -1);
      check("ovr_first_rate_out", int'(rate_out), 3);
      check("ovr_first_overrun", int'(overrun), 0);
      run_window(16'h01FF, 16'h0000, 0, 3);
      check("ovr_rate_out", int'(rate_out), 9);
      check("ovr_rate_valid", int'(rate_valid), 1);
      check("ovr_overrun", int'(overrun), 1);
      ena = 1'b0; rate_ready = 1'b0;
      tick();
      check("abort_keeps_out", int'(rate_out), 9);
      check("abort_keeps_valid", int'(rate_valid), 1);
      rate_ready = 1'b1;
      tick();
      check("idle_hs_valid", int'(rate_valid), 0);
      check("sticky_overrun", int'(overrun), 1);

      // Reset with a pending result and ena held high.
      rate_ready = 1'b0; ena = 1'b1;
      tick();
      run_window(16'h0001, 16'h0000, 0, -1);
      check("pre_rst_rate_valid", int'(rate_valid), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_rate_out", int'(rate_out), 0);
      check("rst_rate_valid", int'(rate_valid), 0);
      check("rst_overrun", int'(overrun), 0);
      check_first("rst", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter WINDOW_LOG2, default 8: window length is 2**WINDOW_LOG2 clock cycles; legal range 2..12.
REQ-002 Parameter COUNT_W, default 8: width of the rate result.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ena  input  1  decoder enable.
REQ-006 spike_in  input  1  spike train from the output neuron; one sample per cycle.
REQ-007 rate_out  output  COUNT_W  spike count of the last completed window.
REQ-008 rate_valid  output  1  rate_out holds an unconsumed result.
REQ-009 rate_ready  input  1  consumer accepts rate_out when rate_valid and rate_ready are both 1.
REQ-010 overrun  output  1  sticky flag; a result was overwritten before it was consumed.

Function
REQ-011 FSM states: IDLE and COUNT.
REQ-012 IDLE->COUNT on ena=1. COUNT->IDLE on ena=0.
REQ-013 Window cycle counter wcnt counts 0..2**WINDOW_LOG2-1 in COUNT; wraps to 0 after the last cycle.
REQ-014 Spike counter: increments on each COUNT cycle with spike_in=1; saturates at 2**COUNT_W-1, no wrap.
REQ-015 Window end (wcnt at max in COUNT): the final count, including that cycle's spike_in, loads rate_out on that edge. rate_valid=1 in the next cycle; latency is 1 cycle after the last window sample.
REQ-016 Window end: the spike counter restarts at 0, or at 1 if spike_in=1 on the first cycle of the new window. No cycle is lost between windows.
REQ-017 Handshake: rate_valid clears on the edge where rate_valid and rate_ready are both 1, unless REQ-019 applies.
REQ-018 rate_out and rate_valid are stable while rate_valid=1 and rate_ready=0, except under REQ-020.
REQ-019 Window end in the same cycle as a handshake: the old value is consumed, the new value loads, rate_valid stays 1, overrun is unchanged.
REQ-020 Window end while rate_valid=1 and rate_ready=0: the new value overwrites rate_out, rate_valid stays 1, overrun is set to 1.
REQ-021 overrun stays 1 until rst.
REQ-022 ena=0 mid-window: on that edge the partial window is discarded, wcnt and the spike counter clear to 0, and the FSM enters IDLE. A pending rate_out and rate_valid are kept and can still be handshaken.
REQ-023 In IDLE, spike_in is ignored and no result is produced.
REQ-024 ena reasserted: counting starts with a fresh window; the first COUNT cycle is wcnt=0.

Reset
REQ-025 rst=1 on an edge sets: FSM=IDLE, wcnt=0, spike counter=0, rate_out=0, rate_valid=0, overrun=0; first-spike outputs also reset (REQ-027).
REQ-026 rst has priority over ena, spike_in and rate_ready. rst mid-window discards all state, including a pending result.

Configuration
REQ-027 With SPIKE_RATE_DECODER_FIRST_SPIKE_EN defined, the block adds these outputs, all reset to 0:
- first_lat  output  WINDOW_LOG2  wcnt of the first spike in the window.
- first_seen  output  1  at least one spike occurred in the window.
- Both load at window end together with rate_out, and follow the same handshake and overwrite rules.
- Window with no spikes: first_seen=0, first_lat=0.
REQ-028 Without the macro, those ports and their logic are absent. All other behaviour is identical.

Structure
REQ-029 Shared package spike_dec_pkg holds:
- the FSM state typedef (IDLE, COUNT);
- default constants for WINDOW_LOG2 and COUNT_W.
REQ-030 The saturating spike counter with synchronous clear/load is the sub-module spike_sat_counter, parameterised by width. The FSM, window counter and handshake stay in the top module.

Verification (WINDOW_LOG2=4, COUNT_W=8 unless stated)
REQ-031 ena=1, spike_in=1 on 5 chosen cycles of a 16-cycle window, rate_ready=1 -> rate_out=5 and rate_valid=1 for one cycle, 1 cycle after the window's last cycle.
REQ-032 spike_in=1 continuously, COUNT_W=3, rate_ready=1 -> rate_out=7 (saturated) every window; no wrap to 0.
REQ-033 rate_ready=0 across two window ends with 3 then 9 spikes -> rate_out=9, rate_valid=1, overrun=1; then rate_ready=1 -> handshake, rate_valid=0, overrun stays 1.
REQ-034 Window end coincides with rate_ready=1 on a pending 4 -> 4 consumed, new value loaded, rate_valid stays 1, overrun=0.
REQ-035 ena dropped at wcnt=9 with 6 spikes counted, then reasserted -> no result from the partial window; the next full window with 2 spikes gives rate_out=2. rst asserted with rate_valid=1 -> all outputs 0 on the next cycle.
REQ-036 With SPIKE_RATE_DECODER_FIRST_SPIKE_EN, first spike at wcnt=3 -> first_lat=3, first_seen=1. Window with no spikes -> first_seen=0, first_lat=0.
